// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy and flag controller for an external DEPTH-entry dual-port RAM
module fifo_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int AFULL_TH = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic             rd_en,
    output logic [PTR_W-1:0] rd_addr,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_N = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_N = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AE_N = CNT_W'(AEMPTY_TH);
    logic push_ok, pop_ok;
    always_comb begin
        empty        = count == '0;
        full         = count == FULL_N;
        almost_empty = count <= AE_N;
        almost_full  = count >= AF_N;
        pop_ok       = pop & ~empty;
        push_ok      = push & (~full | pop_ok);
        wr_en        = push_ok & ~clear;
        rd_en        = pop_ok & ~clear;
    end
    // pointers wrap explicitly so non-power-of-two depths stay in range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_addr <= wr_addr == LAST ? '0 : wr_addr + 1'b1;
            if (pop_ok) rd_addr <= rd_addr == LAST ? '0 : rd_addr + 1'b1;
            count     <= (push_ok & ~pop_ok) ? count + 1'b1 : (pop_ok & ~push_ok) ? count - 1'b1 : count;
            overflow  <= overflow | (push & ~push_ok);
            underflow <= underflow | (pop & ~pop_ok);
        end
    end
endmodule
